uart_core_os: RTL and testbench
===============================

Name: uart_core_os

Overview:
Single-clock UART transceiver that replaces the divided-clock drive structure. Baud timing comes from clock-enable ticks at P_OVERSAMPLE x baud rather than derived clocks. The receiver resynchronises on every start edge, majority-votes each bit, and reports parity and framing errors. It sits between user logic (valid/ready TX, pulse-valid RX) and the board UART pins.

Parameters:
P_SYSTEM_CLK, 50_000_000, i_clk frequency in Hz
P_UART_BURD_RATE, 9600, line baud rate
P_UART_DATA_WIDTH, 8, data bits per frame (5..9)
P_UART_CHECK_ON, 0, parity mode: 0 none, 1 odd, 2 even
P_UART_STOP_WIDTH, 1, stop bits (1 or 2)
P_OVERSAMPLE, 16, ticks per bit (even, >=8)
Derived: L_OS_DIV = P_SYSTEM_CLK/(P_UART_BURD_RATE*P_OVERSAMPLE), must be >=2.

Ports:
i_clk  in  1  system clock; the only clock in the block
i_rst_n  in  1  reset, asynchronous, active-low
i_user_tx_data  in  P_UART_DATA_WIDTH  byte to transmit
i_user_tx_valid  in  1  TX data valid
o_user_tx_ready  out  1  TX able to accept
o_uart_tx  out  1  serial out, idle high
i_uart_rx  in  1  serial in, asynchronous
o_uart_rx_data  out  P_UART_DATA_WIDTH  last received data
o_uart_rx_valid  out  1  one-cycle pulse: new frame complete
o_uart_rx_parity_err  out  1  parity mismatch on last frame
o_uart_rx_frame_err  out  1  stop bit sampled low on last frame

Behaviour:
- Reset (i_rst_n low, asynchronous): o_uart_tx=1, o_user_tx_ready=1, o_uart_rx_data=0, valid/err=0, both FSMs IDLE, counters 0, RX synchroniser flops = 1.
- Tick gen: free-running counter 0..L_OS_DIV-1. os_tick is high for one cycle when count==L_OS_DIV-1.
- TX FSM: IDLE, START, DATA, PARITY (skipped if mode 0), STOP.
  - Handshake fires when valid&&ready in IDLE. Data is latched and ready drops on the next cycle.
  - START begins at the first os_tick after the handshake.
  - Each bit lasts exactly P_OVERSAMPLE ticks. Data is sent LSB first.
  - Parity bit: odd mode makes total ones (data+parity) odd; even mode makes it even.
  - STOP lasts P_UART_STOP_WIDTH bits. Ready rises the cycle after the last stop tick.
  - Valid while not ready is ignored, with no queueing.
- RX input: 2-flop synchroniser, then a falling-edge detect on the synced value.
- RX FSM: IDLE, START, DATA, PARITY, STOP.
  - In IDLE, a falling edge starts the frame. The tick sub-counter is zeroed at that edge, independent of the free-running phase.
  - Samples are taken at sub-counts P_OVERSAMPLE/2-1, /2, /2+1. The bit value is the majority of the three.
  - START: if the majority is 1, treat it as a false start and return to IDLE with no outputs changed.
  - DATA: shift in LSB first.
  - PARITY: compare against the computed value and set the error flag on mismatch.
  - STOP: every stop bit is checked. Any 0 sets frame_err.
  - Completion happens at the mid-sample of the final stop bit: data, parity_err and frame_err update and valid pulses for 1 cycle in the same cycle. The FSM returns to IDLE immediately so back-to-back frames are caught.
  - Valid pulses even when errors are set. The flags qualify the data and hold until the next valid.
- RX and TX are fully independent; simultaneous full-duplex operation is required.
- A line held low (break) yields one frame with data=0 and frame_err=1. No new start is detected until the line has returned high and then falls again.
- Reset mid-frame aborts immediately. No valid pulse is produced for the partial frame.

Test Plan:
Config for all: P_SYSTEM_CLK=1_600_000, BAUD=10_000, OS=16 (L_OS_DIV=10, bit=160 clk).
1. 8N1, TX 0xA5 -> o_uart_tx low 160 clk, then bits 1,0,1,0,0,1,0,1, then high 160 clk. Ready is low for the whole frame and high after.
2. Loopback tx->rx with odd parity, bytes 0x00, 0xFF, 0x3C back-to-back -> three valid pulses with matching data, parity_err=0, frame_err=0. Parity bits driven are 1, 1, 1.
3. RX even parity with a corrupted parity bit on 0x81 -> valid pulse, data=0x81, parity_err=1. The next good frame clears it.
4. RX glitch: low for 40 clk, then high -> no valid pulse, FSM back in IDLE. A following 0x55 frame is received correctly.
5. Stop bit forced low on 0x12, then break of 2000 clk -> frame_err=1 for 0x12. Break gives exactly one frame_err frame with data=0x00, and no further pulses until the line rises.
6. Assert i_rst_n low mid-TX (bit 4) and mid-RX -> o_uart_tx=1 asynchronously, ready=1, no valid pulse. A subsequent 0x5A transfer works.

Source files
------------

// File: rtl/uart_core_os.sv
// Single-clock UART transceiver driven by oversample clock-enable ticks.
// TX: valid/ready in, LSB-first frame out. RX: resynchronises on each start
// edge, majority-votes three mid-bit samples, reports parity/framing errors.
module uart_core_os #(
    parameter int unsigned P_SYSTEM_CLK      = 50_000_000,
    parameter int unsigned P_UART_BURD_RATE  = 9600,
    parameter int unsigned P_UART_DATA_WIDTH = 8,
    parameter int unsigned P_UART_CHECK_ON   = 0,
    parameter int unsigned P_UART_STOP_WIDTH = 1,
    parameter int unsigned P_OVERSAMPLE      = 16
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [P_UART_DATA_WIDTH-1:0] i_user_tx_data,
    input  logic                         i_user_tx_valid,
    output logic                         o_user_tx_ready,
    output logic                         o_uart_tx,
    input  logic                         i_uart_rx,
    output logic [P_UART_DATA_WIDTH-1:0] o_uart_rx_data,
    output logic                         o_uart_rx_valid,
    output logic                         o_uart_rx_parity_err,
    output logic                         o_uart_rx_frame_err
);

    localparam int unsigned L_OS_DIV = P_SYSTEM_CLK / (P_UART_BURD_RATE * P_OVERSAMPLE);
    localparam int unsigned L_DIV_W  = $clog2(L_OS_DIV);
    localparam int unsigned L_SUB_W  = $clog2(P_OVERSAMPLE);
    localparam int unsigned L_BIT_W  = $clog2(P_UART_DATA_WIDTH + 1);
    localparam int unsigned L_DW     = P_UART_DATA_WIDTH;

    localparam logic [L_DIV_W-1:0] L_DIV_LAST  = L_DIV_W'(L_OS_DIV - 1);
    localparam logic [L_SUB_W-1:0] L_SUB_LAST  = L_SUB_W'(P_OVERSAMPLE - 1);
    localparam logic [L_SUB_W-1:0] L_SMP_LO    = L_SUB_W'(P_OVERSAMPLE / 2 - 1);
    localparam logic [L_SUB_W-1:0] L_SMP_MID   = L_SUB_W'(P_OVERSAMPLE / 2);
    localparam logic [L_SUB_W-1:0] L_SMP_HI    = L_SUB_W'(P_OVERSAMPLE / 2 + 1);
    localparam logic [L_BIT_W-1:0] L_DATA_LAST = L_BIT_W'(L_DW - 1);
    localparam logic [L_BIT_W-1:0] L_STOP_LAST = L_BIT_W'(P_UART_STOP_WIDTH - 1);
    localparam bit                 L_PAR_EN    = (P_UART_CHECK_ON != 0);
    localparam bit                 L_PAR_ODD   = (P_UART_CHECK_ON == 1);

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;

    // Parity bit that accompanies a data word in the configured mode
    function automatic logic par_of(input logic [L_DW-1:0] d);
        return L_PAR_ODD ? ~(^d) : (^d);
    endfunction

    logic [L_DIV_W-1:0] os_cnt;
    logic               os_tick;

    assign os_tick = (os_cnt == L_DIV_LAST);

    // Free-running oversample tick divider
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)     os_cnt <= '0;
        else if (os_tick) os_cnt <= '0;
        else              os_cnt <= os_cnt + L_DIV_W'(1);
    end

    // ---------------- transmitter ----------------
    tx_state_e         tx_state_q, tx_state_d;
    logic [L_SUB_W-1:0] tx_sub_q, tx_sub_d;
    logic [L_BIT_W-1:0] tx_bit_q, tx_bit_d;
    logic [L_DW-1:0]    tx_shreg_q, tx_shreg_d;
    logic               tx_par_q, tx_par_d;
    logic               tx_line_d, tx_ready_d;
    logic               tx_bit_end;

    assign tx_bit_end = os_tick && (tx_sub_q == L_SUB_LAST);

    // TX state and output registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tx_state_q      <= TX_IDLE;
            tx_sub_q        <= '0;
            tx_bit_q        <= '0;
            tx_shreg_q      <= '0;
            tx_par_q        <= 1'b0;
            o_uart_tx       <= 1'b1;
            o_user_tx_ready <= 1'b1;
        end else begin
            tx_state_q      <= tx_state_d;
            tx_sub_q        <= tx_sub_d;
            tx_bit_q        <= tx_bit_d;
            tx_shreg_q      <= tx_shreg_d;
            tx_par_q        <= tx_par_d;
            o_uart_tx       <= tx_line_d;
            o_user_tx_ready <= tx_ready_d;
        end
    end

    // TX next state: handshake, then one bit per P_OVERSAMPLE ticks
    always_comb begin
        tx_state_d = tx_state_q;
        tx_sub_d   = tx_sub_q;
        tx_bit_d   = tx_bit_q;
        tx_shreg_d = tx_shreg_q;
        tx_par_d   = tx_par_q;
        tx_line_d  = o_uart_tx;
        tx_ready_d = o_user_tx_ready;
        if (os_tick && (tx_state_q != TX_IDLE))
            tx_sub_d = tx_bit_end ? '0 : tx_sub_q + L_SUB_W'(1);
        case (tx_state_q)
            TX_IDLE: begin
                if (o_user_tx_ready) begin
                    if (i_user_tx_valid) begin
                        tx_shreg_d = i_user_tx_data;
                        tx_par_d   = par_of(i_user_tx_data);
                        tx_ready_d = 1'b0;
                    end
                end else if (os_tick) begin
                    tx_state_d = TX_START;
                    tx_line_d  = 1'b0;
                    tx_sub_d   = '0;
                end
            end
            TX_START: begin
                if (tx_bit_end) begin
                    tx_state_d = TX_DATA;
                    tx_line_d  = tx_shreg_q[0];
                    tx_shreg_d = {1'b0, tx_shreg_q[L_DW-1:1]};
                    tx_bit_d   = '0;
                end
            end
            TX_DATA: begin
                if (tx_bit_end) begin
                    if (tx_bit_q == L_DATA_LAST) begin
                        tx_bit_d = '0;
                        if (L_PAR_EN) begin
                            tx_state_d = TX_PARITY;
                            tx_line_d  = tx_par_q;
                        end else begin
                            tx_state_d = TX_STOP;
                            tx_line_d  = 1'b1;
                        end
                    end else begin
                        tx_bit_d   = tx_bit_q + L_BIT_W'(1);
                        tx_line_d  = tx_shreg_q[0];
                        tx_shreg_d = {1'b0, tx_shreg_q[L_DW-1:1]};
                    end
                end
            end
            TX_PARITY: begin
                if (tx_bit_end) begin
                    tx_state_d = TX_STOP;
                    tx_line_d  = 1'b1;
                    tx_bit_d   = '0;
                end
            end
            TX_STOP: begin
                if (tx_bit_end) begin
                    if (tx_bit_q == L_STOP_LAST) begin
                        tx_state_d = TX_IDLE;
                        tx_ready_d = 1'b1;
                    end else begin
                        tx_bit_d = tx_bit_q + L_BIT_W'(1);
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // ---------------- receiver ----------------
    logic rx_meta, rx_sync, rx_prev, rx_fall, rx_maj;

    // Two-flop synchroniser plus one history flop for edge detection
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= i_uart_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    rx_state_e          rx_state_q, rx_state_d;
    logic [L_SUB_W-1:0] rx_sub_q, rx_sub_d;
    logic [L_BIT_W-1:0] rx_bit_q, rx_bit_d;
    logic [L_DW-1:0]    rx_shreg_q, rx_shreg_d;
    logic               rx_v0_q, rx_v0_d, rx_v1_q, rx_v1_d;
    logic               rx_perr_q, rx_perr_d, rx_ferr_q, rx_ferr_d;
    logic [L_DW-1:0]    rx_data_d;
    logic               rx_valid_d, rx_perr_out_d, rx_ferr_out_d;

    assign rx_fall = rx_prev & ~rx_sync;
    assign rx_maj  = (rx_v0_q & rx_v1_q) | (rx_v0_q & rx_sync) | (rx_v1_q & rx_sync);

    // RX state and output registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_state_q           <= RX_IDLE;
            rx_sub_q             <= '0;
            rx_bit_q             <= '0;
            rx_shreg_q           <= '0;
            rx_v0_q              <= 1'b1;
            rx_v1_q              <= 1'b1;
            rx_perr_q            <= 1'b0;
            rx_ferr_q            <= 1'b0;
            o_uart_rx_data       <= '0;
            o_uart_rx_valid      <= 1'b0;
            o_uart_rx_parity_err <= 1'b0;
            o_uart_rx_frame_err  <= 1'b0;
        end else begin
            rx_state_q           <= rx_state_d;
            rx_sub_q             <= rx_sub_d;
            rx_bit_q             <= rx_bit_d;
            rx_shreg_q           <= rx_shreg_d;
            rx_v0_q              <= rx_v0_d;
            rx_v1_q              <= rx_v1_d;
            rx_perr_q            <= rx_perr_d;
            rx_ferr_q            <= rx_ferr_d;
            o_uart_rx_data       <= rx_data_d;
            o_uart_rx_valid      <= rx_valid_d;
            o_uart_rx_parity_err <= rx_perr_out_d;
            o_uart_rx_frame_err  <= rx_ferr_out_d;
        end
    end

    // RX next state: edge-aligned sub-count, 3-sample vote, finish at last stop mid-sample
    always_comb begin
        rx_state_d    = rx_state_q;
        rx_sub_d      = rx_sub_q;
        rx_bit_d      = rx_bit_q;
        rx_shreg_d    = rx_shreg_q;
        rx_v0_d       = rx_v0_q;
        rx_v1_d       = rx_v1_q;
        rx_perr_d     = rx_perr_q;
        rx_ferr_d     = rx_ferr_q;
        rx_data_d     = o_uart_rx_data;
        rx_valid_d    = 1'b0;
        rx_perr_out_d = o_uart_rx_parity_err;
        rx_ferr_out_d = o_uart_rx_frame_err;
        if (rx_state_q == RX_IDLE) begin
            if (rx_fall) begin
                rx_state_d = RX_START;
                rx_sub_d   = '0;
                rx_perr_d  = 1'b0;
                rx_ferr_d  = 1'b0;
            end
        end else if (os_tick) begin
            rx_sub_d = (rx_sub_q == L_SUB_LAST) ? '0 : rx_sub_q + L_SUB_W'(1);
            if (rx_sub_q == L_SMP_LO) rx_v0_d = rx_sync;
            if (rx_sub_q == L_SMP_MID) begin
                rx_v1_d = rx_sync;
                // final stop bit closes the frame so the next start edge is not missed
                if ((rx_state_q == RX_STOP) && (rx_bit_q == L_STOP_LAST)) begin
                    rx_state_d    = RX_IDLE;
                    rx_data_d     = rx_shreg_q;
                    rx_perr_out_d = rx_perr_q;
                    rx_ferr_out_d = rx_ferr_q | ~(rx_v0_q & rx_sync);
                    rx_valid_d    = 1'b1;
                end
            end
            if (rx_sub_q == L_SMP_HI) begin
                case (rx_state_q)
                    RX_START: begin
                        if (rx_maj) begin
                            rx_state_d = RX_IDLE;
                        end else begin
                            rx_state_d = RX_DATA;
                            rx_bit_d   = '0;
                        end
                    end
                    RX_DATA: begin
                        rx_shreg_d = {rx_maj, rx_shreg_q[L_DW-1:1]};
                        if (rx_bit_q == L_DATA_LAST) begin
                            rx_bit_d   = '0;
                            rx_state_d = L_PAR_EN ? RX_PARITY : RX_STOP;
                        end else begin
                            rx_bit_d = rx_bit_q + L_BIT_W'(1);
                        end
                    end
                    RX_PARITY: begin
                        rx_perr_d  = (rx_maj != par_of(rx_shreg_q));
                        rx_state_d = RX_STOP;
                        rx_bit_d   = '0;
                    end
                    RX_STOP: begin
                        if (!rx_maj) rx_ferr_d = 1'b1;
                        rx_bit_d = rx_bit_q + L_BIT_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_core_os.sv
// Bench for uart_core_os: three instances (8N1, odd-parity loopback, even parity)
// checked against a bit-level frame model built from each byte.
module tb_uart_core_os;

    localparam int BITC = 160;

    logic       clk;
    logic       rst_n;
    logic [7:0] a_txd, b_txd, c_txd;
    logic       a_txv, b_txv, c_txv;
    logic       a_rdy, b_rdy, c_rdy;
    logic       a_tx, b_tx, c_tx;
    logic       line_a, line_c;
    logic [7:0] a_rxd, b_rxd, c_rxd;
    logic       a_rxv, b_rxv, c_rxv;
    logic       a_pe, b_pe, c_pe;
    logic       a_fe, b_fe, c_fe;

    int tests = 0;
    int fails = 0;

    typedef struct packed {logic [7:0] d; logic pe; logic fe;} rx_t;
    rx_t  a_q[$], b_q[$], c_q[$];
    logic b_par_q[$];
    logic [7:0] b_dec_q[$];
    logic [10:0] mon_s;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_core_os #(.P_SYSTEM_CLK(1_600_000), .P_UART_BURD_RATE(10_000), .P_UART_DATA_WIDTH(8),
                   .P_UART_CHECK_ON(0), .P_UART_STOP_WIDTH(1), .P_OVERSAMPLE(16)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_user_tx_data(a_txd), .i_user_tx_valid(a_txv),
        .o_user_tx_ready(a_rdy), .o_uart_tx(a_tx), .i_uart_rx(line_a), .o_uart_rx_data(a_rxd),
        .o_uart_rx_valid(a_rxv), .o_uart_rx_parity_err(a_pe), .o_uart_rx_frame_err(a_fe));

    uart_core_os #(.P_SYSTEM_CLK(1_600_000), .P_UART_BURD_RATE(10_000), .P_UART_DATA_WIDTH(8),
                   .P_UART_CHECK_ON(1), .P_UART_STOP_WIDTH(1), .P_OVERSAMPLE(16)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_user_tx_data(b_txd), .i_user_tx_valid(b_txv),
        .o_user_tx_ready(b_rdy), .o_uart_tx(b_tx), .i_uart_rx(b_tx), .o_uart_rx_data(b_rxd),
        .o_uart_rx_valid(b_rxv), .o_uart_rx_parity_err(b_pe), .o_uart_rx_frame_err(b_fe));

    uart_core_os #(.P_SYSTEM_CLK(1_600_000), .P_UART_BURD_RATE(10_000), .P_UART_DATA_WIDTH(8),
                   .P_UART_CHECK_ON(2), .P_UART_STOP_WIDTH(1), .P_OVERSAMPLE(16)) u_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_user_tx_data(c_txd), .i_user_tx_valid(c_txv),
        .o_user_tx_ready(c_rdy), .o_uart_tx(c_tx), .i_uart_rx(line_c), .o_uart_rx_data(c_rxd),
        .o_uart_rx_valid(c_rxv), .o_uart_rx_parity_err(c_pe), .o_uart_rx_frame_err(c_fe));

    // Collect every RX completion pulse
    always @(negedge clk) begin
        if (a_rxv === 1'b1) a_q.push_back({a_rxd, a_pe, a_fe});
        if (b_rxv === 1'b1) b_q.push_back({b_rxd, b_pe, b_fe});
        if (c_rxv === 1'b1) c_q.push_back({c_rxd, c_pe, c_fe});
    end

    // Decode B's serial line at bit centres (start, 8 data, parity, stop)
    initial forever begin
        @(negedge b_tx);
        repeat (BITC / 2) @(negedge clk);
        for (int i = 0; i < 11; i++) begin
            mon_s[i] = b_tx;
            if (i < 10) repeat (BITC) @(negedge clk);
        end
        b_dec_q.push_back(mon_s[8:1]);
        b_par_q.push_back(mon_s[9]);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic par_bit(input logic [7:0] d, input int mode);
        int ones;
        ones = $countones(d);
        if (mode == 1) return 1'((ones % 2) == 0);
        if (mode == 2) return 1'((ones % 2) == 1);
        return 1'b0;
    endfunction

    function automatic int qsize(input int which);
        if (which == 0) return a_q.size();
        if (which == 1) return b_q.size();
        return c_q.size();
    endfunction

    function automatic logic rdy(input int which);
        if (which == 0) return a_rdy;
        if (which == 1) return b_rdy;
        return c_rdy;
    endfunction

    task automatic set_txv(input int which, input logic v, input logic [7:0] d);
        if (which == 0) begin a_txv = v; a_txd = d; end
        else if (which == 1) begin b_txv = v; b_txd = d; end
        else begin c_txv = v; c_txd = d; end
    endtask

    task automatic set_line(input int which, input logic v);
        if (which == 0) line_a = v;
        else line_c = v;
    endtask

    // Wait (bounded) for ready, then hold valid for exactly one accepting edge
    task automatic send_tx(input int which, input logic [7:0] d);
        int k = 0;
        while (rdy(which) !== 1'b1 && k < 4000) begin @(negedge clk); k++; end
        check("tx_ready_wait", 32'(rdy(which)), 32'd1);
        set_txv(which, 1'b1, d);
        @(posedge clk);
        #1 set_txv(which, 1'b0, d);
    endtask

    // Drive one serial frame onto an RX line (which: 0 = A, 2 = C)
    task automatic drive_frame(input int which, input logic [7:0] d, input int mode,
                               input logic flip, input logic stop_v);
        set_line(which, 1'b0);
        repeat (BITC) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            set_line(which, d[i]);
            repeat (BITC) @(posedge clk);
        end
        if (mode != 0) begin
            set_line(which, par_bit(d, mode) ^ flip);
            repeat (BITC) @(posedge clk);
        end
        set_line(which, stop_v);
        repeat (BITC) @(posedge clk);
        set_line(which, 1'b1);
    endtask

    task automatic wait_rx(input int which, input int n, input int budget, input string tag);
        int k = 0;
        while (qsize(which) < n && k < budget) begin @(negedge clk); k++; end
        repeat (20) @(negedge clk);
        check(tag, 32'(qsize(which)), 32'(n));
    endtask

    // Send a byte on A and compare the line cycle-by-cycle with the 8N1 frame model
    task automatic check_tx_frame_a(input logic [7:0] d);
        logic [9:0] bits;
        int berr[10];
        int rerr = 0;
        int lowcnt = 0;
        int k = 0;
        for (int b = 0; b < 10; b++) berr[b] = 0;
        bits = {1'b1, d, 1'b0};
        send_tx(0, d);
        check("tx_ready_drop", 32'(a_rdy), 32'd0);
        while (a_tx !== 1'b0 && k < 100) begin @(negedge clk); k++; end
        check("tx_start_seen", 32'(a_tx), 32'd0);
        for (int c = 0; c < 10 * BITC; c++) begin
            if (a_tx !== bits[c / BITC]) berr[c / BITC]++;
            if (a_rdy !== 1'b0) rerr++;
            if (c == 500) set_txv(0, 1'b1, ~d);
            if (c == 501) set_txv(0, 1'b0, ~d);
            @(negedge clk);
        end
        for (int b = 0; b < 10; b++) check($sformatf("tx_bit%0d_%02h", b, d), 32'(berr[b]), 32'd0);
        check("tx_ready_low_in_frame", 32'(rerr), 32'd0);
        check("tx_ready_rise", 32'(a_rdy), 32'd1);
        check("tx_idle_high", 32'(a_tx), 32'd1);
        for (int c = 0; c < 300; c++) begin
            if (a_tx !== 1'b1) lowcnt++;
            @(negedge clk);
        end
        check("tx_busy_valid_ignored", 32'(lowcnt), 32'd0);
    endtask

    initial begin : main
        logic [7:0] bl[6];
        logic [7:0] r;
        int k;
        int lowcnt;

        rst_n = 1'b0;
        line_a = 1'b1;
        line_c = 1'b1;
        set_txv(0, 1'b0, 8'h00);
        set_txv(1, 1'b0, 8'h00);
        set_txv(2, 1'b0, 8'h00);
        repeat (5) @(negedge clk);
        check("rst_tx", 32'(a_tx), 32'd1);
        check("rst_ready", 32'(a_rdy), 32'd1);
        check("rst_rx_data", 32'(a_rxd), 32'd0);
        check("rst_rx_valid", 32'(a_rxv), 32'd0);
        check("rst_perr", 32'(a_pe), 32'd0);
        check("rst_ferr", 32'(a_fe), 32'd0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // 8N1 transmit waveform
        check_tx_frame_a(8'hA5);
        check_tx_frame_a(8'($urandom));

        // Odd-parity loopback, back-to-back frames
        bl[0] = 8'h00; bl[1] = 8'hFF; bl[2] = 8'h3C;
        for (int i = 3; i < 6; i++) bl[i] = 8'($urandom);
        b_q.delete(); b_par_q.delete(); b_dec_q.delete();
        for (int i = 0; i < 6; i++) send_tx(1, bl[i]);
        wait_rx(1, 6, 4000, "loop_count");
        check("loop_par_count", 32'(b_par_q.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (b_q.size() > i) begin
                check($sformatf("loop_data%0d", i), 32'(b_q[i].d), 32'(bl[i]));
                check($sformatf("loop_perr%0d", i), 32'(b_q[i].pe), 32'd0);
                check($sformatf("loop_ferr%0d", i), 32'(b_q[i].fe), 32'd0);
            end
            if (b_par_q.size() > i) begin
                check($sformatf("loop_parbit%0d", i), 32'(b_par_q[i]), 32'(par_bit(bl[i], 1)));
                check($sformatf("loop_line%0d", i), 32'(b_dec_q[i]), 32'(bl[i]));
            end
        end

        // Even parity: corrupted parity bit, then a clean frame clears the flag
        c_q.delete();
        drive_frame(2, 8'h81, 2, 1'b1, 1'b1);
        wait_rx(2, 1, 400, "cpar_bad_count");
        if (c_q.size() > 0) begin
            check("cpar_bad_data", 32'(c_q[0].d), 32'h81);
            check("cpar_bad_perr", 32'(c_q[0].pe), 32'd1);
            check("cpar_bad_ferr", 32'(c_q[0].fe), 32'd0);
        end
        check("cpar_flag_held", 32'(c_pe), 32'd1);
        r = 8'($urandom);
        drive_frame(2, r, 2, 1'b0, 1'b1);
        wait_rx(2, 2, 400, "cpar_good_count");
        if (c_q.size() > 1) begin
            check("cpar_good_data", 32'(c_q[1].d), 32'(r));
            check("cpar_good_perr", 32'(c_q[1].pe), 32'd0);
        end

        // Short glitch is a false start; the following frame still decodes
        a_q.delete();
        line_a = 1'b0;
        repeat (40) @(posedge clk);
        line_a = 1'b1;
        repeat (400) @(negedge clk);
        check("glitch_no_valid", 32'(a_q.size()), 32'd0);
        drive_frame(0, 8'h55, 0, 1'b0, 1'b1);
        wait_rx(0, 1, 400, "after_glitch_count");
        if (a_q.size() > 0) begin
            check("after_glitch_data", 32'(a_q[0].d), 32'h55);
            check("after_glitch_ferr", 32'(a_q[0].fe), 32'd0);
        end

        // Low stop bit, then a long break
        a_q.delete();
        drive_frame(0, 8'h12, 0, 1'b0, 1'b0);
        wait_rx(0, 1, 400, "badstop_count");
        if (a_q.size() > 0) begin
            check("badstop_data", 32'(a_q[0].d), 32'h12);
            check("badstop_ferr", 32'(a_q[0].fe), 32'd1);
        end
        repeat (320) @(negedge clk);
        a_q.delete();
        line_a = 1'b0;
        repeat (2000) @(negedge clk);
        check("break_one_frame", 32'(a_q.size()), 32'd1);
        line_a = 1'b1;
        repeat (500) @(negedge clk);
        check("break_after_rise", 32'(a_q.size()), 32'd1);
        if (a_q.size() > 0) begin
            check("break_data", 32'(a_q[0].d), 32'h00);
            check("break_ferr", 32'(a_q[0].fe), 32'd1);
            check("break_perr", 32'(a_q[0].pe), 32'd0);
        end

        // Asynchronous reset in the middle of TX and RX frames
        a_q.delete();
        send_tx(0, 8'hC3);
        k = 0;
        while (a_tx !== 1'b0 && k < 100) begin @(negedge clk); k++; end
        check("rst_mid_start_seen", 32'(a_tx), 32'd0);
        line_a = 1'b0;
        repeat (5 * BITC + BITC / 2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_tx_high", 32'(a_tx), 32'd1);
        check("rst_mid_ready", 32'(a_rdy), 32'd1);
        line_a = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        lowcnt = 0;
        for (int c = 0; c < 2000; c++) begin
            if (a_tx !== 1'b1) lowcnt++;
            @(negedge clk);
        end
        check("rst_mid_tx_stays_idle", 32'(lowcnt), 32'd0);
        check("rst_mid_no_valid", 32'(a_q.size()), 32'd0);
        check_tx_frame_a(8'h5A);
        drive_frame(0, 8'h5A, 0, 1'b0, 1'b1);
        wait_rx(0, 1, 400, "post_rst_rx_count");
        if (a_q.size() > 0) begin
            check("post_rst_rx_data", 32'(a_q[0].d), 32'h5A);
            check("post_rst_rx_ferr", 32'(a_q[0].fe), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
